// File: rtl/po_fpga_job_scheduler.sv
// -----------------------------------------------------------------------------
// po_fpga_job_scheduler
//
// Multi-core job dispatcher for the PO point-generation engine. One go_i
// request starts a batch of num_jobs_i generation runs. Runs are issued
// round-robin to idle cores, one per cycle at most, and completion pulses are
// collected until the whole batch is finished. At that point done pulses once.
//
// Optional feature macro: PO_SCHED_TIMEOUT_EN
//   When it is defined, each core gets a watchdog. A core that stays busy for
//   TIMEOUT_CYCLES is forcibly freed, its job counts as completed and
//   err_timeout is set. When it is undefined, err_timeout is tied low and a
//   hung core stalls the batch.
//
// Ports
//   clk             sole clock, rising edge
//   reset           synchronous, active-high reset
//   go_i            one-cycle batch start, sampled only in IDLE
//   num_jobs_i      batch size, captured together with go_i
//   core_go         one-hot, one-cycle start pulse to a core
//   core_done       one-cycle completion pulse from each core
//   dispatch_valid  high in the cycle a core_go bit is high
//   dispatch_core   index of the core being started
//   dispatch_job    0-based job index being started
//   busy            high in RUN and DONE
//   done            one-cycle pulse at the end of a batch
//   jobs_completed  completions in the current or last batch
//   cycle_count     RUN cycles of the current or last batch, saturating
//   err_spurious    sticky: core_done seen from a core that was not busy
//   err_timeout     sticky: a watchdog fired
// -----------------------------------------------------------------------------
module po_fpga_job_scheduler #(
    parameter int NUM_CORES      = 4,
    parameter int JOB_W          = 8,
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 go_i,
    input  logic [JOB_W-1:0]     num_jobs_i,
    output logic [NUM_CORES-1:0] core_go,
    input  logic [NUM_CORES-1:0] core_done,
    output logic                 dispatch_valid,
    output logic [3:0]           dispatch_core,
    output logic [JOB_W-1:0]     dispatch_job,
    output logic                 busy,
    output logic                 done,
    output logic [JOB_W-1:0]     jobs_completed,
    output logic [CNT_W-1:0]     cycle_count,
    output logic                 err_spurious,
    output logic                 err_timeout
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]           state;
    logic [1:0]           next_state;
    logic [JOB_W-1:0]     num_jobs;
    logic [JOB_W-1:0]     issued;
    logic [3:0]           rr;
    logic [NUM_CORES-1:0] core_busy;

    logic                 start_batch;
    logic [JOB_W-1:0]     target_jobs;
    logic [JOB_W-1:0]     issued_now;
    logic                 can_issue;
    logic                 found;
    logic [3:0]           pick;
    logic [3:0]           next_rr;
    logic                 do_dispatch;
    logic [NUM_CORES-1:0] go_vec;
    logic [NUM_CORES-1:0] timeout_free;
    logic [NUM_CORES-1:0] valid_done;
    logic [NUM_CORES-1:0] spurious;
    logic [JOB_W-1:0]     done_cnt;
    logic [JOB_W-1:0]     completed_next;

    // The first dispatch is decided in the same cycle go_i is accepted so that
    // core_go appears one cycle after go_i. In that cycle the freshly offered
    // batch size and a zero issue count stand in for the not-yet-loaded
    // registers.
    always_comb begin
        start_batch = (state == ST_IDLE) && go_i;
        target_jobs = start_batch ? num_jobs_i : num_jobs;
        issued_now  = start_batch ? '0 : issued;
        can_issue   = (start_batch || (state == ST_RUN)) && (issued_now < target_jobs);
    end

    // Round-robin search: first idle core at or after rr, wrapping. The search
    // looks at the registered busy bits, so a core freed this cycle cannot be
    // picked until the next one.
    always_comb begin
        int cand;
        found = 1'b0;
        pick  = '0;
        cand  = 0;
        for (int i = 0; i < NUM_CORES; i++) begin
            cand = int'(rr) + i;
            if (cand >= NUM_CORES) begin
                cand = cand - NUM_CORES;
            end
            if (!found && !core_busy[cand]) begin
                found = 1'b1;
                pick  = 4'(cand);
            end
        end
        next_rr     = (int'(pick) == NUM_CORES - 1) ? 4'd0 : pick + 4'd1;
        do_dispatch = can_issue && found;
        go_vec      = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            go_vec[k] = do_dispatch && (int'(pick) == k);
        end
    end

`ifdef PO_SCHED_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    logic [WD_W-1:0] wd_count [NUM_CORES];

    // A real completion arriving in the same cycle as the watchdog limit wins,
    // so the job is counted once and no timeout is flagged.
    always_comb begin
        timeout_free = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            timeout_free[k] = core_busy[k] && !core_done[k] &&
                              (wd_count[k] == WD_W'(TIMEOUT_CYCLES));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_CORES; k++) begin
                wd_count[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_CORES; k++) begin
                if (go_vec[k]) begin
                    wd_count[k] <= '0;
                end else if (core_busy[k] && !valid_done[k]) begin
                    wd_count[k] <= wd_count[k] + WD_W'(1);
                end
            end
        end
    end
`else
    assign timeout_free = '0;
`endif

    // Completion accounting: only cores that are busy may complete; anything
    // else is a protocol error. Several cores may finish in one cycle.
    always_comb begin
        valid_done = (core_done & core_busy) | timeout_free;
        spurious   = core_done & ~core_busy;
        done_cnt   = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            done_cnt = done_cnt + JOB_W'(valid_done[k]);
        end
        completed_next = jobs_completed + done_cnt;
    end

    // The batch ends in the cycle after the last completion is seen, which is
    // why the RUN exit looks at the post-update completion count.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (go_i) next_state = ST_RUN;
            ST_RUN:  if (completed_next == num_jobs) next_state = ST_DONE;
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            num_jobs       <= '0;
            issued         <= '0;
            rr             <= '0;
            core_busy      <= '0;
            core_go        <= '0;
            dispatch_valid <= 1'b0;
            dispatch_core  <= '0;
            dispatch_job   <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            jobs_completed <= '0;
            cycle_count    <= '0;
            err_spurious   <= 1'b0;
            err_timeout    <= 1'b0;
        end else begin
            state          <= next_state;
            busy           <= (next_state == ST_RUN) || (next_state == ST_DONE);
            done           <= (state == ST_RUN) && (next_state == ST_DONE);
            core_go        <= go_vec;
            dispatch_valid <= do_dispatch;
            core_busy      <= (core_busy & ~valid_done) | go_vec;

            if (do_dispatch) begin
                dispatch_core <= pick;
                dispatch_job  <= issued_now;
                issued        <= issued_now + JOB_W'(1);
                rr            <= next_rr;
            end else if (start_batch) begin
                issued <= '0;
            end

            if (start_batch) begin
                num_jobs       <= num_jobs_i;
                jobs_completed <= '0;
                cycle_count    <= '0;
                err_spurious   <= |spurious;
                err_timeout    <= 1'b0;
            end else begin
                err_spurious <= err_spurious | (|spurious);
                err_timeout  <= err_timeout | (|timeout_free);
                if (state == ST_RUN) begin
                    jobs_completed <= completed_next;
                    if (cycle_count != '1) begin
                        cycle_count <= cycle_count + CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_po_fpga_job_scheduler.sv
// -----------------------------------------------------------------------------
// tb_po_fpga_job_scheduler
//
// Self-checking bench for po_fpga_job_scheduler with NUM_CORES=4. Behavioural
// core models answer each core_go with a core_done after a per-core delay
// (0 = never). Expected dispatches (core, job, cycle offset from go_i) are
// queued when a batch is started and popped as core_go pulses appear. Batch
// level results come from a table; reset, spurious-done and watchdog cases
// are written out by hand.
// -----------------------------------------------------------------------------
module tb_po_fpga_job_scheduler;

    localparam int NUM_CORES      = 4;
    localparam int JOB_W          = 8;
    localparam int CNT_W          = 32;
    localparam int TIMEOUT_CYCLES = 20;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 go_i;
    logic [JOB_W-1:0]     num_jobs_i;
    logic [NUM_CORES-1:0] core_go;
    logic [NUM_CORES-1:0] core_done;
    logic                 dispatch_valid;
    logic [3:0]           dispatch_core;
    logic [JOB_W-1:0]     dispatch_job;
    logic                 busy;
    logic                 done;
    logic [JOB_W-1:0]     jobs_completed;
    logic [CNT_W-1:0]     cycle_count;
    logic                 err_spurious;
    logic                 err_timeout;

    always #5 clk = ~clk;

    po_fpga_job_scheduler #(
        .NUM_CORES      (NUM_CORES),
        .JOB_W          (JOB_W),
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .go_i           (go_i),
        .num_jobs_i     (num_jobs_i),
        .core_go        (core_go),
        .core_done      (core_done),
        .dispatch_valid (dispatch_valid),
        .dispatch_core  (dispatch_core),
        .dispatch_job   (dispatch_job),
        .busy           (busy),
        .done           (done),
        .jobs_completed (jobs_completed),
        .cycle_count    (cycle_count),
        .err_spurious   (err_spurious),
        .err_timeout    (err_timeout)
    );

    typedef struct {
        int num_jobs;
        int d0;
        int d1;
        int d2;
        int d3;
        int done_off;
        int completed;
        int cycles;
    } batch_vec_t;

    typedef struct {
        int batch;
        int core;
        int job;
        int off;
    } disp_vec_t;

    typedef struct {
        int core;
        int job;
        int off;
    } disp_exp_t;

    int checks      = 0;
    int errors      = 0;
    int cyc         = 0;
    int go_cyc      = 0;
    int done_pulses = 0;
    int dly [NUM_CORES];
    int cnt [NUM_CORES];
    logic [NUM_CORES-1:0] model_done = '0;
    logic [NUM_CORES-1:0] force_done = '0;
    disp_exp_t sb_q [$];

    assign core_done = model_done | force_done;

    // Cycle index; at a falling edge it names the cycle currently in progress.
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Core models: a core started in cycle g finishes in cycle g + delay.
    initial forever begin
        @(negedge clk);
        for (int k = 0; k < NUM_CORES; k++) begin
            model_done[k] = (cnt[k] == 1);
            if (core_go[k]) begin
                cnt[k] = dly[k];
            end else if (cnt[k] > 0) begin
                cnt[k] = cnt[k] - 1;
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Dispatch monitor: every core_go pulse must match the head of the queue.
    initial forever begin
        disp_exp_t e;
        logic [NUM_CORES-1:0] exp_go;
        @(negedge clk);
        if (done) done_pulses++;
        if (dispatch_valid || (core_go != '0)) begin
            if (sb_q.size() == 0) begin
                checkOutput("unexpected_dispatch_core", int'(dispatch_core), -1);
            end else begin
                e = sb_q.pop_front();
                exp_go = '0;
                exp_go[e.core] = 1'b1;
                checkOutput("dispatch_onehot", int'(core_go), int'(exp_go));
                checkOutput("dispatch_valid", int'(dispatch_valid), 1);
                checkOutput("dispatch_core", int'(dispatch_core), e.core);
                checkOutput("dispatch_job", int'(dispatch_job), e.job);
                checkOutput("dispatch_time", cyc - go_cyc, e.off);
            end
        end
    end

    task automatic pushDispatch(input int core, input int job, input int off);
        disp_exp_t e;
        e.core = core;
        e.job  = job;
        e.off  = off;
        sb_q.push_back(e);
    endtask

    // Drives a one-cycle go_i; returns in the cycle after go_i was sampled.
    task automatic applyStimulus(input int nj, input int d0, input int d1, input int d2, input int d3);
        dly[0] = d0;
        dly[1] = d1;
        dly[2] = d2;
        dly[3] = d3;
        @(negedge clk);
        #1;
        go_i        = 1'b1;
        num_jobs_i  = JOB_W'(nj);
        go_cyc      = cyc;
        done_pulses = 0;
        @(negedge clk);
        #1;
        go_i       = 1'b0;
        num_jobs_i = JOB_W'(7);
    endtask

    task automatic waitDone(input int limit, output int off);
        off = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            #1;
            if (done) begin
                off = cyc - go_cyc;
                break;
            end
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_core_go"}, int'(core_go), 0);
        checkOutput({tag, "_dispatch_valid"}, int'(dispatch_valid), 0);
        checkOutput({tag, "_dispatch_core"}, int'(dispatch_core), 0);
        checkOutput({tag, "_dispatch_job"}, int'(dispatch_job), 0);
        checkOutput({tag, "_busy"}, int'(busy), 0);
        checkOutput({tag, "_done"}, int'(done), 0);
        checkOutput({tag, "_jobs_completed"}, int'(jobs_completed), 0);
        checkOutput({tag, "_cycle_count"}, int'(cycle_count), 0);
        checkOutput({tag, "_err_spurious"}, int'(err_spurious), 0);
        checkOutput({tag, "_err_timeout"}, int'(err_timeout), 0);
    endtask

    batch_vec_t batches [5];
    disp_vec_t  disps [19];

    initial begin
        int off;

        // Batch table: jobs, per-core delays, done offset, completions, cycles.
        batches[0] = '{3, 10, 10, 10, 10, 14, 3, 13};
        batches[1] = '{9,  4,  6,  5, 10, 24, 9, 23};
        batches[2] = '{0,  3,  3,  3,  3,  2, 0,  1};
        batches[3] = '{2,  3,  3,  3,  3,  6, 2,  5};
        batches[4] = '{5,  2,  2,  2,  2,  8, 5,  7};

        // Dispatch table: batch, core, job, cycle offset from go_i.
        disps[0]  = '{0, 0, 0, 1};
        disps[1]  = '{0, 1, 1, 2};
        disps[2]  = '{0, 2, 2, 3};
        disps[3]  = '{1, 3, 0, 1};
        disps[4]  = '{1, 0, 1, 2};
        disps[5]  = '{1, 1, 2, 3};
        disps[6]  = '{1, 2, 3, 4};
        disps[7]  = '{1, 0, 4, 8};
        disps[8]  = '{1, 1, 5, 11};
        disps[9]  = '{1, 2, 6, 12};
        disps[10] = '{1, 3, 7, 13};
        disps[11] = '{1, 0, 8, 14};
        disps[12] = '{3, 1, 0, 1};
        disps[13] = '{3, 2, 1, 2};
        disps[14] = '{4, 3, 0, 1};
        disps[15] = '{4, 0, 1, 2};
        disps[16] = '{4, 1, 2, 3};
        disps[17] = '{4, 2, 3, 4};
        disps[18] = '{4, 3, 4, 5};

        reset      = 1'b1;
        go_i       = 1'b0;
        num_jobs_i = '0;
        repeat (3) @(negedge clk);
        #1;
        checkResetValues("reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int b = 0; b < 5; b++) begin
            for (int d = 0; d < 19; d++) begin
                if (disps[d].batch == b) pushDispatch(disps[d].core, disps[d].job, disps[d].off);
            end
            applyStimulus(batches[b].num_jobs, batches[b].d0, batches[b].d1, batches[b].d2, batches[b].d3);
            waitDone(200, off);
            checkOutput("done_offset", off, batches[b].done_off);
            checkOutput("jobs_completed", int'(jobs_completed), batches[b].completed);
            checkOutput("cycle_count", int'(cycle_count), batches[b].cycles);
            checkOutput("busy_at_done", int'(busy), 1);
            checkOutput("err_spurious_batch", int'(err_spurious), 0);
            checkOutput("err_timeout_batch", int'(err_timeout), 0);
            @(negedge clk);
            #1;
            checkOutput("busy_after_done", int'(busy), 0);
            checkOutput("done_width", int'(done), 0);
            repeat (3) @(negedge clk);
            #1;
            checkOutput("dispatches_left", sb_q.size(), 0);
            checkOutput("done_pulses", done_pulses, 1);
            checkOutput("jobs_completed_hold", int'(jobs_completed), batches[b].completed);
        end

        // Spurious completion from idle core 3.
        @(negedge clk);
        #1;
        force_done = 4'b1000;
        @(negedge clk);
        #1;
        force_done = '0;
        checkOutput("spurious_set", int'(err_spurious), 1);
        checkOutput("spurious_no_count", int'(jobs_completed), 5);
        repeat (3) @(negedge clk);
        #1;
        checkOutput("spurious_sticky", int'(err_spurious), 1);

        // Next batch clears the sticky flag; rr continues at core 0.
        pushDispatch(0, 0, 1);
        applyStimulus(1, 3, 3, 3, 3);
        checkOutput("spurious_cleared", int'(err_spurious), 0);
        waitDone(100, off);
        checkOutput("clear_batch_done_offset", off, 5);
        checkOutput("clear_batch_completed", int'(jobs_completed), 1);
        repeat (3) @(negedge clk);

        // Reset in the middle of a batch with cores 1 and 2 busy.
        pushDispatch(1, 0, 1);
        pushDispatch(2, 1, 2);
        applyStimulus(2, 10, 10, 10, 10);
        repeat (2) @(negedge clk);
        #1;
        checkOutput("busy_before_reset", int'(busy), 1);
        reset = 1'b1;
        @(negedge clk);
        #1;
        checkResetValues("midreset");
        reset = 1'b0;
        checkOutput("midreset_dispatches_left", sb_q.size(), 0);
        repeat (12) @(negedge clk);
        #1;
        checkOutput("stale_done_spurious", int'(err_spurious), 1);
        checkOutput("stale_done_no_count", int'(jobs_completed), 0);
        checkOutput("stale_done_idle", int'(busy), 0);

        // Fresh batch after reset starts at core 0.
        pushDispatch(0, 0, 1);
        applyStimulus(1, 3, 3, 3, 3);
        waitDone(100, off);
        checkOutput("post_reset_done_offset", off, 5);
        checkOutput("post_reset_completed", int'(jobs_completed), 1);
        repeat (3) @(negedge clk);
        #1;
        checkOutput("post_reset_dispatches_left", sb_q.size(), 0);

`ifdef PO_SCHED_TIMEOUT_EN
        // Hung core: the watchdog frees it and the batch still completes.
        pushDispatch(1, 0, 1);
        applyStimulus(1, 0, 0, 0, 0);
        waitDone(100, off);
        checkOutput("timeout_done_offset", off, 22);
        checkOutput("timeout_flag", int'(err_timeout), 1);
        checkOutput("timeout_completed", int'(jobs_completed), 1);
        checkOutput("timeout_no_spurious", int'(err_spurious), 0);
        repeat (3) @(negedge clk);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
